piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in, serial-out front end for the left-shift serial register chain.
- Accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock, LSB first, on ser_out.
- ser_out drives the D input of the downstream serial-serial shift register directly.
- Inserts a configurable idle gap between words so downstream framing stays aligned.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
GAP, 1, idle cycles between the last bit of one word and the return to IDLE; legal range 0..255.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
data_in  input  WIDTH  parallel word to serialize.
load_valid  input  1  producer has a word on data_in.
load_ready  output  1  serializer can accept a word this cycle.
ser_out  output  1  serial data bit, LSB first; feeds downstream D.
ser_valid  output  1  ser_out carries a word bit this cycle.
busy  output  1  high in SHIFT and GAP.
done  output  1  one-cycle pulse, coincident with the last (MSB) bit.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high, sampled on the rising edge.
- rst has priority over every other input.
- State after rst:
  - state=IDLE; shift register, bit counter and gap counter = 0.
  - ser_out=0, ser_valid=0, busy=0, done=0, load_ready=1.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - load_ready=1, ser_out=0, ser_valid=0.
  - On an edge with load_valid=1: capture data_in into the shift register, clear the bit counter, go to SHIFT.
- SHIFT:
  - ser_out = shift_reg[0]; ser_valid=1; busy=1; load_ready=0.
  - Each edge: shift register shifts right by one, zero-filled; bit counter increments.
  - done=1 while bit counter = WIDTH-1.
  - On the edge ending bit WIDTH-1: go to GAP if GAP>0, otherwise go to IDLE.
- GAP:
  - ser_out=0, ser_valid=0, busy=1, load_ready=0.
  - Stays GAP cycles, counted by the gap counter, then returns to IDLE.
- Latency: the first bit (data_in[0]) is on ser_out in the cycle immediately after the accepting edge. The word occupies exactly WIDTH consecutive cycles.
- Throughput: minimum spacing between accepting edges is WIDTH+GAP+1 cycles (IDLE always lasts at least one cycle).
- load_valid while load_ready=0: ignored. No capture and no queuing; the producer must hold load_valid until accepted.
- data_in changes after acceptance have no effect on the word in flight.
- All outputs are driven from registers or decoded from registered state only. No combinational path from inputs to outputs.
- load_ready depends on state only, not on load_valid.
- Reset mid-word: the next edge with rst=1 aborts the word, with no partial done. Outputs return to reset values in the following cycle.
- Reset asserted together with load_valid in IDLE: the word is not captured.

Test Plan:
1. WIDTH=8, GAP=1, rst high 2 cycles, then data_in=8'b0000_1101 with load_valid=1 for one cycle in IDLE -> ser_out = 1,0,1,1,0,0,0,0 over the next 8 cycles; ser_valid=1 for exactly those 8; done=1 only on the 8th; ser_out=0 and busy=1 in the following GAP cycle; load_ready=1 in the cycle after that.
2. load_valid held high, data_in=8'hA5 then changed to 8'h3C right after the first accept -> bits 1,0,1,0,0,1,0,1, then 0,0,1,1,1,1,0,0; second accept edge exactly 10 cycles after the first.
3. During SHIFT of 8'hFF, pulse load_valid with data_in=8'h00 at bit 3 -> serial stream stays all ones for 8 bits; 8'h00 is never emitted.
4. Assert rst during bit 4 of 8'hF0 -> next cycle ser_out=0, ser_valid=0, busy=0, done=0, load_ready=1; no done pulse for the aborted word.
5. Instance with GAP=0, two words 8'h01 and 8'h80 offered back-to-back -> one IDLE cycle with ser_valid=0 between words; accept spacing 9 cycles.
6. WIDTH=4, GAP=3, data_in=4'b1001 -> ser_out 1,0,0,1; done on 4th bit; busy high for 7 cycles total.

Source files
------------

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - load handshake and serial output bundle for piso_serializer
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;

  modport master (
    output data_in, load_valid,
    input  load_ready, ser_out, ser_valid, busy, done
  );

  modport slave (
    input  data_in, load_valid,
    output load_ready, ser_out, ser_valid, busy, done
  );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out front end, LSB first, with idle gap
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input logic               clk,
  input logic               rst,
  piso_serializer_if.slave  bus
);
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [7:0]    LAST_GAP = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shift_reg, shift_n;
  logic [CW-1:0]    bit_cnt, bit_n;
  logic [7:0]       gap_cnt, gap_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      bit_cnt   <= bit_n;
      gap_cnt   <= gap_n;
    end
  end

  // Outputs decode registered state only, so there is no input-to-output path.
  always_comb begin
    state_n        = state;
    shift_n        = shift_reg;
    bit_n          = bit_cnt;
    gap_n          = gap_cnt;
    bus.load_ready = 1'b0;
    bus.ser_out    = 1'b0;
    bus.ser_valid  = 1'b0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.load_ready = 1'b1;
        if (bus.load_valid) begin
          shift_n = bus.data_in;
          bit_n   = '0;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bus.ser_out   = shift_reg[0];
        bus.ser_valid = 1'b1;
        bus.busy      = 1'b1;
        bus.done      = (bit_cnt == LAST_BIT);
        shift_n       = shift_reg >> 1;
        bit_n         = bit_cnt + CW'(1);
        if (bit_cnt == LAST_BIT) begin
          bit_n   = '0;
          gap_n   = '0;
          state_n = (GAP > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        bus.busy = 1'b1;
        if (gap_cnt == LAST_GAP) begin
          gap_n   = '0;
          state_n = ST_IDLE;
        end else begin
          gap_n = gap_cnt + 8'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for three piso_serializer configurations
module tb_piso_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(8)) b0 ();
  piso_serializer_if #(.WIDTH(8)) b1 ();
  piso_serializer_if #(.WIDTH(4)) b2 ();

  piso_serializer #(.WIDTH(8), .GAP(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  piso_serializer #(.WIDTH(8), .GAP(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
  piso_serializer #(.WIDTH(4), .GAP(3)) u2 (.clk(clk), .rst(rst), .bus(b2));

  int          wid [3] = '{8, 8, 4};
  int          gp  [3] = '{1, 0, 3};
  logic        vld [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] din [3] = '{32'd0, 32'd0, 32'd0};
  int          cnt [3] = '{0, 0, 0};
  int          busy_seen [3] = '{0, 0, 0};
  bit          exp_q [3][$];
  int          acc_cyc [3][$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  assign b0.load_valid = vld[0];
  assign b0.data_in    = din[0][7:0];
  assign b1.load_valid = vld[1];
  assign b1.data_in    = din[1][7:0];
  assign b2.load_valid = vld[2];
  assign b2.data_in    = din[2][3:0];

  // {load_ready, ser_out, ser_valid, busy, done}
  function automatic logic [4:0] obs(int i);
    case (i)
      0:       return {b0.load_ready, b0.ser_out, b0.ser_valid, b0.busy, b0.done};
      1:       return {b1.load_ready, b1.ser_out, b1.ser_valid, b1.busy, b1.done};
      default: return {b2.load_ready, b2.ser_out, b2.ser_valid, b2.busy, b2.done};
    endcase
  endfunction

  task automatic chk(string tag, int i, int o, int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s[%0d] cyc=%0d observed=%0d expected=%0d", tag, i, cyc, o, e);
    end
  endtask

  task automatic step();
    bit         acc [3];
    logic [4:0] o;
    bit         eb;
    for (int i = 0; i < 3; i++) acc[i] = !rst && (cnt[i] == 0) && vld[i];
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        cnt[i] = 0;
        exp_q[i].delete();
      end else if (acc[i]) begin
        cnt[i] = wid[i] + gp[i];
        for (int b = 0; b < wid[i]; b++) exp_q[i].push_back(din[i][b]);
        acc_cyc[i].push_back(cyc);
      end else if (cnt[i] > 0) begin
        cnt[i]--;
      end
      o = obs(i);
      if (o[1]) busy_seen[i]++;
      chk("load_ready", i, int'(o[4]), int'(cnt[i] == 0));
      chk("busy",       i, int'(o[1]), int'(cnt[i] > 0));
      chk("ser_valid",  i, int'(o[2]), int'(cnt[i] > gp[i]));
      if (cnt[i] > gp[i] && exp_q[i].size() > 0) begin
        eb = exp_q[i].pop_front();
        chk("ser_out", i, int'(o[3]), int'(eb));
        chk("done",    i, int'(o[0]), int'(cnt[i] == gp[i] + 1));
      end else begin
        chk("ser_out_idle", i, int'(o[3]), 0);
        chk("done_idle",    i, int'(o[0]), 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // word 0x0D on the GAP=1 instance
    vld[0] = 1'b1; din[0] = 32'h0D;
    step();
    vld[0] = 1'b0;
    repeat (11) step();

    // held load_valid: 0xA5 then 0x3C, accepts 10 cycles apart
    vld[0] = 1'b1; din[0] = 32'hA5;
    step();
    din[0] = 32'h3C;
    repeat (10) step();
    vld[0] = 1'b0;
    repeat (11) step();
    chk("accept_spacing", 0, acc_cyc[0][$] - acc_cyc[0][$-1], 10);

    // load_valid pulse during SHIFT is ignored
    vld[0] = 1'b1; din[0] = 32'hFF;
    step();
    vld[0] = 1'b0;
    repeat (3) step();
    vld[0] = 1'b1; din[0] = 32'h00;
    step();
    vld[0] = 1'b0;
    repeat (10) step();

    // reset mid-word aborts without done
    vld[0] = 1'b1; din[0] = 32'hF0;
    step();
    vld[0] = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // reset together with load_valid in IDLE captures nothing
    rst = 1'b1; vld[0] = 1'b1; din[0] = 32'hFF;
    step();
    rst = 1'b0; vld[0] = 1'b0;
    repeat (3) step();

    // GAP=0 back-to-back words, accepts 9 cycles apart
    vld[1] = 1'b1; din[1] = 32'h01;
    step();
    din[1] = 32'h80;
    repeat (9) step();
    vld[1] = 1'b0;
    repeat (10) step();
    chk("accept_spacing", 1, acc_cyc[1][$] - acc_cyc[1][$-1], 9);

    // WIDTH=4, GAP=3: busy for 7 cycles
    busy_seen[2] = 0;
    vld[2] = 1'b1; din[2] = 32'h9;
    step();
    vld[2] = 1'b0;
    repeat (9) step();
    chk("busy_cycles", 2, busy_seen[2], 7);

    for (int i = 0; i < 3; i++) chk("sb_drained", i, exp_q[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
